// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Constants and types shared by the SPI master TX and RX
//                control paths. Holds the default byte width, the pending
//                slot state encoding used by the RX controller, and
//                common SPI mode defaults used by the TX controller.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

    // Default SPI byte width (must match the SPI master core data width)
    localparam int c_spi_data_width     = 8;

    // Largest supported number of bytes packed into one RX FIFO word
    localparam int c_spi_max_pack_bytes = 8;

    // SPI mode defaults shared with the TX controller
    localparam logic c_spi_cpol_default = 1'b0;
    localparam logic c_spi_cpha_default = 1'b0;

    // Width of the SPI serial clock divider used by the TX controller
    localparam int c_spi_clk_div_width  = 8;

    // Pending slot state of the RX controller
    typedef enum logic [0:0] {
        P_EMPTY = 1'b0,
        P_FULL  = 1'b1
    } pend_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_rx_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_rx_byte_packer
//  Description : Packs consecutive received SPI bytes into one word. The
//                first byte lands in the LSBs. A word completes when its
//                last byte arrives or when flush is seen with at least one
//                byte collected; missing bytes are zero.
//                o_word_done is a combinational pulse in the cycle the
//                completing byte/flush is presented, with o_word valid in
//                that same cycle.
//  Ports       : clk, rst      clock, synchronous active-high reset
//                i_valid       one received byte this cycle
//                i_data        received byte
//                i_flush       complete a partial word now
//                o_word_done   word complete this cycle
//                o_word        completed word (valid with o_word_done)
//                o_busy        partial word held in the accumulator
//  Revision    : 1.0  initial release
// ============================================================================
module spi_rx_byte_packer
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = c_spi_data_width,
    parameter int PACK_BYTES = 4,
    localparam int WORD_WIDTH = DATA_WIDTH * PACK_BYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_flush,
    output logic                  o_word_done,
    output logic [WORD_WIDTH-1:0] o_word,
    output logic                  o_busy
);

    localparam int IDX_W = (PACK_BYTES > 1) ? $clog2(PACK_BYTES) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(PACK_BYTES - 1);

    logic [IDX_W-1:0]      r_idx;
    logic [WORD_WIDTH-1:0] r_acc;
    logic [IDX_W-1:0]      w_idx_next;
    logic [WORD_WIDTH-1:0] w_merged;
    logic                  w_done;

    // The accumulator is cleared after every completed word, so all byte
    // lanes at or above r_idx are already zero: this is the flush padding.
    always_comb begin
        w_merged = r_acc;
        for (int k = 0; k < PACK_BYTES; k++) begin
            if (i_valid && (r_idx == IDX_W'(k))) begin
                w_merged[k*DATA_WIDTH +: DATA_WIDTH] = i_data;
            end
        end
    end

    // Flush completes the word if any byte is held, counting a byte that
    // arrives in the same cycle.
    always_comb begin
        w_done = (i_valid && (r_idx == c_last_idx)) ||
                 (i_flush && (i_valid || (r_idx != '0)));
        if (w_done) begin
            w_idx_next = '0;
        end else if (i_valid) begin
            w_idx_next = r_idx + IDX_W'(1);
        end else begin
            w_idx_next = r_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_acc <= '0;
        end else begin
            r_idx <= w_idx_next;
            r_acc <= w_done ? '0 : w_merged;
        end
    end

    assign o_word_done = w_done;
    assign o_word      = w_merged;
    assign o_busy      = (r_idx != '0);

endmodule
`default_nettype wire

// File: rtl/spi_master_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_rx_ctrl
//  Description : SPI master receive control path. Packs received bytes into
//                FIFO words, buffers one completed word in a pending slot
//                against a full FIFO, and reports dropped words through a
//                sticky overflow flag and a saturating drop counter.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                spi_rx_data_valid   one received byte this cycle
//                spi_rx_data         received byte
//                flush               emit a partially packed word
//                overflow_clr        clear the sticky overflow flag
//                fifo_full           RX FIFO full
//                fifo_write_en       FIFO write strobe
//                fifo_write_data     FIFO write data (zero when idle)
//                overflow            sticky: at least one word dropped
//                drop_count          dropped words, saturating
//                rx_busy             partial or pending word held
//  Revision    : 1.0  initial release
// ============================================================================
module spi_master_rx_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH     = c_spi_data_width,
    parameter int PACK_BYTES     = 4,
    parameter int DROP_CNT_WIDTH = 16,
    localparam int FIFO_WIDTH    = DATA_WIDTH * PACK_BYTES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spi_rx_data_valid,
    input  logic [DATA_WIDTH-1:0]     spi_rx_data,
    input  logic                      flush,
    input  logic                      overflow_clr,
    input  logic                      fifo_full,
    output logic                      fifo_write_en,
    output logic [FIFO_WIDTH-1:0]     fifo_write_data,
    output logic                      overflow,
    output logic [DROP_CNT_WIDTH-1:0] drop_count,
    output logic                      rx_busy
);

    logic                      w_word_done;
    logic [FIFO_WIDTH-1:0]     w_word;
    logic                      w_pack_busy;

    pend_state_t               r_state;
    pend_state_t               w_state_next;
    logic [FIFO_WIDTH-1:0]     r_pend;
    logic [FIFO_WIDTH-1:0]     w_pend_next;
    logic                      w_drain;
    logic                      w_drop;
    logic                      r_overflow;
    logic [DROP_CNT_WIDTH-1:0] r_drop_count;

    spi_rx_byte_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .PACK_BYTES (PACK_BYTES)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (spi_rx_data_valid),
        .i_data      (spi_rx_data),
        .i_flush     (flush),
        .o_word_done (w_word_done),
        .o_word      (w_word),
        .o_busy      (w_pack_busy)
    );

    assign w_drain = (r_state == P_FULL) && !fifo_full;

    // Pending slot: a completed word is accepted when the slot is empty or
    // is being written to the FIFO in this same cycle; otherwise it drops.
    always_comb begin
        w_state_next = r_state;
        w_pend_next  = r_pend;
        w_drop       = 1'b0;
        case (r_state)
            P_EMPTY: begin
                if (w_word_done) begin
                    w_state_next = P_FULL;
                    w_pend_next  = w_word;
                end
            end
            P_FULL: begin
                if (w_drain) begin
                    if (w_word_done) begin
                        w_state_next = P_FULL;
                        w_pend_next  = w_word;
                    end else begin
                        w_state_next = P_EMPTY;
                    end
                end else if (w_word_done) begin
                    w_drop = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= P_EMPTY;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
        end
    end

    // A drop in the same cycle as overflow_clr leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + DROP_CNT_WIDTH'(1);
            end
        end
    end

    assign fifo_write_en   = w_drain;
    assign fifo_write_data = w_drain ? r_pend : '0;
    assign overflow        = r_overflow;
    assign drop_count      = r_drop_count;
    assign rx_busy         = w_pack_busy || (r_state == P_FULL);

endmodule
`default_nettype wire

// File: tb/tb_spi_master_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_rx_ctrl
//  Description : Self-checking bench for spi_master_rx_ctrl. A table of
//                hand-derived per-cycle vectors, a hand-written reset
//                sequence, and randomized traffic compared every cycle
//                against a queue-based behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_master_rx_ctrl;

    localparam int DW  = 8;
    localparam int PB  = 4;
    localparam int FW  = DW * PB;
    localparam int DCW = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           spi_rx_data_valid;
    logic [DW-1:0]  spi_rx_data;
    logic           flush;
    logic           overflow_clr;
    logic           fifo_full;
    logic           fifo_write_en;
    logic [FW-1:0]  fifo_write_data;
    logic           overflow;
    logic [DCW-1:0] drop_count;
    logic           rx_busy;

    spi_master_rx_ctrl #(
        .DATA_WIDTH     (DW),
        .PACK_BYTES     (PB),
        .DROP_CNT_WIDTH (DCW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .spi_rx_data_valid (spi_rx_data_valid),
        .spi_rx_data       (spi_rx_data),
        .flush             (flush),
        .overflow_clr      (overflow_clr),
        .fifo_full         (fifo_full),
        .fifo_write_en     (fifo_write_en),
        .fifo_write_data   (fifo_write_data),
        .overflow          (overflow),
        .drop_count        (drop_count),
        .rx_busy           (rx_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic           v;
        logic [DW-1:0]  d;
        logic           f;
        logic           c;
        logic           full;
        logic           we;
        logic [FW-1:0]  wd;
        logic           ovf;
        logic [DCW-1:0] drop;
        logic           busy;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: bytes collected so far, one pending word, flags.
    logic [DW-1:0] m_bytes[$];
    bit            m_pend_v;
    logic [FW-1:0] m_pend;
    bit            m_ovf;
    int            m_drops;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic v, input logic [DW-1:0] d, input logic f,
                                input logic c, input logic full, input logic we,
                                input logic [FW-1:0] wd, input logic ovf,
                                input logic [DCW-1:0] drop, input logic busy);
        vec_t e;
        e.v = v; e.d = d; e.f = f; e.c = c; e.full = full;
        e.we = we; e.wd = wd; e.ovf = ovf; e.drop = drop; e.busy = busy;
        vecs.push_back(e);
    endfunction

    task automatic model_clear();
        m_bytes.delete();
        m_pend_v = 1'b0;
        m_pend   = '0;
        m_ovf    = 1'b0;
        m_drops  = 0;
    endtask

    task automatic model_step(input logic v, input logic [DW-1:0] d, input logic f,
                              input logic c, input logic full);
        bit            done;
        bit            dropped;
        bit            drain;
        logic [FW-1:0] w;
        done    = 1'b0;
        dropped = 1'b0;
        w       = '0;
        drain   = m_pend_v && !full;
        if (v) m_bytes.push_back(d);
        if ((m_bytes.size() == PB) || (f && (m_bytes.size() > 0))) begin
            done = 1'b1;
            foreach (m_bytes[i]) w[i*DW +: DW] = m_bytes[i];
            m_bytes.delete();
        end
        if (drain) m_pend_v = 1'b0;
        if (done) begin
            if (!m_pend_v) begin
                m_pend_v = 1'b1;
                m_pend   = w;
            end else begin
                dropped = 1'b1;
            end
        end
        if (dropped) begin
            m_ovf = 1'b1;
            if (m_drops < (2**DCW - 1)) m_drops++;
        end else if (c) begin
            m_ovf = 1'b0;
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs
    // either against a table vector or the model, then advance the model.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic f,
                         input logic c, input logic full, input bit use_vec,
                         input vec_t e, input string tag);
        logic m_we;
        @(negedge clk);
        spi_rx_data_valid = v;
        spi_rx_data       = d;
        flush             = f;
        overflow_clr      = c;
        fifo_full         = full;
        #1;
        if (use_vec) begin
            chk({tag, " we"},   64'(fifo_write_en),   64'(e.we));
            chk({tag, " data"}, 64'(fifo_write_data), 64'(e.wd));
            chk({tag, " ovf"},  64'(overflow),        64'(e.ovf));
            chk({tag, " drop"}, 64'(drop_count),      64'(e.drop));
            chk({tag, " busy"}, 64'(rx_busy),         64'(e.busy));
        end else begin
            m_we = m_pend_v && !full;
            chk({tag, " we"},   64'(fifo_write_en),   64'(m_we));
            chk({tag, " data"}, 64'(fifo_write_data), m_we ? 64'(m_pend) : 64'd0);
            chk({tag, " ovf"},  64'(overflow),        64'(m_ovf));
            chk({tag, " drop"}, 64'(drop_count),      64'(m_drops));
            chk({tag, " busy"}, 64'(rx_busy),         64'((m_bytes.size() != 0) || m_pend_v));
        end
        model_step(v, d, f, c, full);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        spi_rx_data_valid = 1'b0;
        spi_rx_data = '0;
        flush = 1'b0;
        overflow_clr = 1'b0;
        fifo_full = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_clear();
        chk("reset we",   64'(fifo_write_en),   64'd0);
        chk("reset data", 64'(fifo_write_data), 64'd0);
        chk("reset ovf",  64'(overflow),        64'd0);
        chk("reset drop", 64'(drop_count),      64'd0);
        chk("reset busy", 64'(rx_busy),         64'd0);
    endtask

    initial begin
        vec_t none;
        logic full_r;
        none = '{default: '0};
        rst = 1'b1;
        spi_rx_data_valid = 1'b0;
        spi_rx_data = '0;
        flush = 1'b0;
        overflow_clr = 1'b0;
        fifo_full = 1'b0;
        model_clear();

        // v, d, flush, clr, full | we, data, ovf, drop, busy
        // Four spaced bytes
        add(1, 8'h11, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0, 32'h0, 0, 0, 1);
        add(1, 8'h22, 0, 0, 0, 0, 32'h0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 32'h0, 0, 0, 1);
        add(1, 8'h33, 0, 0, 0, 0, 32'h0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 32'h0, 0, 0, 1);
        add(1, 8'h44, 0, 0, 0, 0, 32'h0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 1, 32'h44332211, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        // Back-to-back bytes
        add(1, 8'h01, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        add(1, 8'h02, 0, 0, 0, 0, 32'h0, 0, 0, 1);
        add(1, 8'h03, 0, 0, 0, 0, 32'h0, 0, 0, 1);
        add(1, 8'h04, 0, 0, 0, 0, 32'h0, 0, 0, 1);
        add(1, 8'h05, 0, 0, 0, 1, 32'h04030201, 0, 0, 1);
        add(1, 8'h06, 0, 0, 0, 0, 32'h0, 0, 0, 1);
        add(1, 8'h07, 0, 0, 0, 0, 32'h0, 0, 0, 1);
        add(1, 8'h08, 0, 0, 0, 0, 32'h0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 1, 32'h08070605, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        // Flush cases
        add(1, 8'hAA, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        add(1, 8'hBB, 0, 0, 0, 0, 32'h0, 0, 0, 1);
        add(0, 8'h00, 1, 0, 0, 0, 32'h0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 1, 32'h0000BBAA, 0, 0, 1);
        add(0, 8'h00, 1, 0, 0, 0, 32'h0, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        add(1, 8'hCC, 1, 0, 0, 0, 32'h0, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 1, 32'h000000CC, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        // Pending drains in the cycle the next word completes
        add(1, 8'h10, 0, 0, 1, 0, 32'h0, 0, 0, 0);
        add(1, 8'h11, 0, 0, 1, 0, 32'h0, 0, 0, 1);
        add(1, 8'h12, 0, 0, 1, 0, 32'h0, 0, 0, 1);
        add(1, 8'h13, 0, 0, 1, 0, 32'h0, 0, 0, 1);
        add(1, 8'h20, 0, 0, 1, 0, 32'h0, 0, 0, 1);
        add(1, 8'h21, 0, 0, 1, 0, 32'h0, 0, 0, 1);
        add(1, 8'h22, 0, 0, 1, 0, 32'h0, 0, 0, 1);
        add(1, 8'h23, 0, 0, 0, 1, 32'h13121110, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 1, 32'h23222120, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        // FIFO full during 12 bytes: first word held, two dropped
        add(1, 8'hC0, 0, 0, 1, 0, 32'h0, 0, 0, 0);
        add(1, 8'hC1, 0, 0, 1, 0, 32'h0, 0, 0, 1);
        add(1, 8'hC2, 0, 0, 1, 0, 32'h0, 0, 0, 1);
        add(1, 8'hC3, 0, 0, 1, 0, 32'h0, 0, 0, 1);
        add(1, 8'hC4, 0, 0, 1, 0, 32'h0, 0, 0, 1);
        add(1, 8'hC5, 0, 0, 1, 0, 32'h0, 0, 0, 1);
        add(1, 8'hC6, 0, 0, 1, 0, 32'h0, 0, 0, 1);
        add(1, 8'hC7, 0, 0, 1, 0, 32'h0, 0, 0, 1);
        add(1, 8'hC8, 0, 0, 1, 0, 32'h0, 1, 1, 1);
        add(1, 8'hC9, 0, 0, 1, 0, 32'h0, 1, 1, 1);
        add(1, 8'hCA, 0, 0, 1, 0, 32'h0, 1, 1, 1);
        add(1, 8'hCB, 0, 0, 1, 0, 32'h0, 1, 1, 1);
        add(0, 8'h00, 0, 0, 0, 1, 32'hC3C2C1C0, 1, 2, 1);
        add(0, 8'h00, 0, 0, 0, 0, 32'h0, 1, 2, 0);
        add(0, 8'h00, 0, 1, 0, 0, 32'h0, 1, 2, 0);
        add(0, 8'h00, 0, 0, 0, 0, 32'h0, 0, 2, 0);

        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].v, vecs[i].d, vecs[i].f, vecs[i].c, vecs[i].full,
                  1'b1, vecs[i], $sformatf("vec%0d", i));
        end

        // Reset mid-word discards the partial word
        cycle(1, 8'hE1, 0, 0, 0, 1'b0, none, "pre-rst b0");
        cycle(1, 8'hE2, 0, 0, 0, 1'b0, none, "pre-rst b1");
        do_reset();
        cycle(1, 8'h55, 0, 0, 0, 1'b0, none, "post-rst b0");
        cycle(1, 8'h56, 0, 0, 0, 1'b0, none, "post-rst b1");
        cycle(1, 8'h57, 0, 0, 0, 1'b0, none, "post-rst b2");
        cycle(1, 8'h58, 0, 0, 0, 1'b0, none, "post-rst b3");
        chk("post-rst no early write", 64'(fifo_write_en), 64'd0);
        cycle(0, 8'h00, 0, 0, 0, 1'b0, none, "post-rst out");
        chk("post-rst write en",   64'(fifo_write_en),   64'd1);
        chk("post-rst write data", 64'(fifo_write_data), 64'h58575655);

        // Randomized traffic against the model
        do_reset();
        full_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) full_r = ~full_r;
            cycle(1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0),
                  full_r, 1'b0, none, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master_rx_ctrl.md
Name: spi_master_rx_ctrl

Overview:
Receive-side companion to the SPI master TX control path. Accepts byte-wide receive pulses from the SPI master core and packs PACK_BYTES consecutive bytes into one FIFO word. Writes each completed word into the RX FIFO, which the host drains. Provides one-word elastic buffering against a full FIFO, plus sticky overflow reporting and a saturating drop counter.

Parameters:
DATA_WIDTH, 8, SPI byte width; must match SPI master RX data width.
PACK_BYTES, 4, bytes per FIFO word; legal range 1..8.
DROP_CNT_WIDTH, 16, width of dropped-word counter.
Derived localparam FIFO_WIDTH = DATA_WIDTH*PACK_BYTES.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
spi_rx_data_valid  in  1  single-cycle pulse, one received byte
spi_rx_data  in  DATA_WIDTH  received byte, valid with pulse
flush  in  1  pulse: emit partially packed word now
overflow_clr  in  1  pulse: clear sticky overflow flag
fifo_full  in  1  RX FIFO full flag
fifo_write_en  out  1  FIFO write enable, active high
fifo_write_data  out  FIFO_WIDTH  FIFO write data
overflow  out  1  sticky: at least one word dropped
drop_count  out  DROP_CNT_WIDTH  dropped words, saturating
rx_busy  out  1  partial word in accumulator or pending word held

Behaviour:
- Reset: clock clk; reset rst is synchronous, active-high. All registers clear. Outputs after reset: fifo_write_en=0, fifo_write_data=0, overflow=0, drop_count=0, rx_busy=0. Reset mid-word discards both the partial word and the pending word without a FIFO write.
- Accumulator: byte index idx counts 0..PACK_BYTES-1 and wraps to 0. Byte k of a word is stored at bits [k*DATA_WIDTH +: DATA_WIDTH], so the first byte occupies the LSBs. A valid byte at idx = PACK_BYTES-1 completes the word.
- Flush: when idx > 0, flush completes the word with unfilled bytes zero-padded. When idx = 0, flush is a no-op. If valid and flush occur in the same cycle, the byte is stored first, then flush applies; no padding is added if that byte itself completes the word.
- Pending slot: a two-state FSM, P_EMPTY or P_FULL, holding one FIFO_WIDTH word.
  - A completed word moves to pending at the clock edge, provided pending is empty or drains in the same cycle.
  - Otherwise the completed word is dropped: overflow sets, and drop_count increments (holding at all-ones).
- FIFO write:
  - fifo_write_en = (state==P_FULL) && !fifo_full.
  - fifo_write_data = pending word when fifo_write_en is high, else 0.
  - On a write, pending returns to P_EMPTY unless refilled in the same edge.
  - Latency: word-completing byte sampled at edge N, then fifo_write_en is high during cycle N+1 if fifo_full is low.
- fifo_full high: pending is held indefinitely and the accumulator continues to collect bytes.
- overflow_clr and a drop in the same cycle: the set wins. drop_count is cleared only by rst.
- rx_busy = (idx != 0) || (state==P_FULL).
- PACK_BYTES=1: every valid byte completes a word, and flush is always a no-op.

Decomposition:
- Shared package spi_pkg holds:
  - default DATA_WIDTH;
  - the FSM state encodings P_EMPTY=1'b0 and P_FULL=1'b1;
  - the shared SPI constants used by the TX and RX controllers.
- One natural sub-module, spi_rx_byte_packer: contains the accumulator, idx counter and flush/padding logic, and outputs a word_done pulse plus the word. The pending FSM, counters and FIFO interface stay in the top level.

Test Plan:
- Four spaced valid bytes 0x11,0x22,0x33,0x44, fifo_full=0 -> single fifo_write_en pulse one cycle after the 4th byte, data 0x44332211; rx_busy returns to 0.
- Back-to-back valid every cycle, 8 bytes 0x01..0x08 -> writes 0x04030201 then 0x08070605, each one cycle after its completing byte, with no drops.
- fifo_full=1 while 12 bytes arrive -> first word held, second and third words dropped; overflow=1, drop_count=2. Release fifo_full -> first word written, no others. overflow_clr -> overflow=0 while drop_count stays 2.
- Bytes 0xAA,0xBB then flush -> write 0x0000BBAA. Flush with idx=0 -> no write. Byte 0xCC with flush on the same cycle at idx=0 -> write 0x000000CC.
- Two bytes received, then rst for 1 cycle, then 4 bytes 0x55..0x58 -> no write for the discarded bytes; next write is 0x58575655.
- Pending drains in the same cycle a new word completes (fifo_full deasserts on that cycle) -> both words written on consecutive cycles, drop_count=0.
